// File: rtl/rate_enable_gen_pkg.sv
// Shared encodings and defaults for the rate_enable_gen pacing stage.
package rate_enable_gen_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_FAST = 2'b00;
  localparam rate_t RATE_1    = 2'b01;
  localparam rate_t RATE_2    = 2'b10;
  localparam rate_t RATE_3    = 2'b11;

  // Defaults give 1 Hz / 0.5 Hz / 0.25 Hz from a 50 MHz clock.
  localparam int unsigned CNT_W_DEFAULT = 28;
  localparam int unsigned DIV1_DEFAULT  = 50_000_000;
  localparam int unsigned DIV2_DEFAULT  = 100_000_000;
  localparam int unsigned DIV3_DEFAULT  = 200_000_000;

endpackage

// File: rtl/rate_enable_gen_if.sv
// Control/status bundle between the button/switch front end and the pacing stage.
interface rate_enable_gen_if;
  import rate_enable_gen_pkg::*;

  rate_t Rate;
  logic  Toggle;
  logic  Step;
  logic  Enable;
  logic  Running;

  modport master (
    output Rate,
    output Toggle,
    output Step,
    input  Enable,
    input  Running
  );

  modport slave (
    input  Rate,
    input  Toggle,
    input  Step,
    output Enable,
    output Running
  );

endinterface

// File: rtl/rate_enable_gen_edge_sync.sv
// Two-flop synchronizer with a rising-edge detect on the synchronized level.
module rate_enable_gen_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronizer chain plus one flop of history for the edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/rate_enable_gen.sv
// Pacing stage: emits single-cycle Enable pulses at one of four rates, with
// run/stop toggle and single-step while stopped.
module rate_enable_gen
  import rate_enable_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned DIV1  = DIV1_DEFAULT,
  parameter int unsigned DIV2  = DIV2_DEFAULT,
  parameter int unsigned DIV3  = DIV3_DEFAULT
) (
  input logic              Clock,
  input logic              Clear_b,
  rate_enable_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] RELOAD1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] RELOAD2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] RELOAD3 = CNT_W'(DIV3 - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] reload;
  rate_t            rate_q;
  logic             enable_q;
  logic             toggle_rise;
  logic             step_rise;
  logic             rate_chg;

  rate_enable_gen_edge_sync u_toggle_sync (
    .clk     (Clock),
    .reset_n (Clear_b),
    .d       (bus.Toggle),
    .rise    (toggle_rise)
  );

  rate_enable_gen_edge_sync u_step_sync (
    .clk     (Clock),
    .reset_n (Clear_b),
    .d       (bus.Step),
    .rise    (step_rise)
  );

  assign rate_chg = (bus.Rate != rate_q);

  // Reload for the rate now on the input; the fast rate reloads 0 so the
  // divider expires every cycle, which is exactly the divide-by-1 behaviour.
  always_comb begin
    reload = '0;
    unique case (bus.Rate)
      RATE_FAST: reload = '0;
      RATE_1:    reload = RELOAD1;
      RATE_2:    reload = RELOAD2;
      RATE_3:    reload = RELOAD3;
    endcase
  end

  // Run/stop FSM, divider and registered Enable; Toggle outranks Step.
  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q  <= ST_STOPPED;
      cnt_q    <= '0;
      rate_q   <= RATE_FAST;
      enable_q <= 1'b0;
    end else begin
      rate_q   <= bus.Rate;
      enable_q <= 1'b0;
      if (toggle_rise) begin
        if (state_q == ST_STOPPED) begin
          state_q <= ST_RUNNING;
          cnt_q   <= reload;
        end else begin
          // Divider holds; re-entry reloads it anyway.
          state_q <= ST_STOPPED;
        end
      end else if (state_q == ST_RUNNING) begin
        if (rate_chg) begin
          // New rate restarts a full period and suppresses this cycle's pulse.
          cnt_q <= reload;
        end else if (cnt_q == '0) begin
          enable_q <= 1'b1;
          cnt_q    <= reload;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else begin
        enable_q <= step_rise;
      end
    end
  end

  assign bus.Enable  = enable_q;
  assign bus.Running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_rate_enable_gen.sv
// Self-checking bench for rate_enable_gen: table vectors, directed corner
// sequences, then randomized stimulus against a deadline-based reference model.
module tb_rate_enable_gen;

  localparam int NVEC = 44;
  localparam int NRND = 3000;

  typedef struct packed {
    logic       tog;
    logic       stp;
    logic [1:0] rate;
    logic       en;
    logic       run;
  } vec_t;

  logic Clock;
  logic Clear_b;
  int   checks;
  int   passed;

  rate_enable_gen_if bus ();

  rate_enable_gen #(
    .CNT_W (8),
    .DIV1  (4),
    .DIV2  (8),
    .DIV3  (16)
  ) dut (
    .Clock   (Clock),
    .Clear_b (Clear_b),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  // Drive inputs just after an edge, advance one edge, settle for sampling.
  task automatic cyc(input logic tog, input logic stp, input logic [1:0] rate);
    bus.Toggle = tog;
    bus.Step   = stp;
    bus.Rate   = rate;
    @(posedge Clock);
    #1;
  endtask

  task automatic cyc_chk(input string name, input logic tog, input logic stp,
                         input logic [1:0] rate, input logic en, input logic run);
    cyc(tog, stp, rate);
    check({name, "_enable"}, bus.Enable, en);
    check({name, "_running"}, bus.Running, run);
  endtask

  function automatic int div_of(input logic [1:0] rate);
    case (rate)
      2'b01:   return 4;
      2'b10:   return 8;
      2'b11:   return 16;
      default: return 1;
    endcase
  endfunction

  vec_t       vecs [NVEC];
  logic       tog_a [NRND];
  logic       stp_a [NRND];
  logic [1:0] rate_a [NRND];

  initial begin
    logic       tog_l, stp_l, t_act, s_act, chg, exp_en, run_m;
    logic [1:0] rate_l, prev_rate;
    int         next_due;

    checks = 0;
    passed = 0;

    // 20 idle cycles, then a Toggle rise at j=0: entry edge j=2, pulses every 4.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].rate = 2'b01;
      vecs[i].stp  = 1'b0;
      vecs[i].tog  = (i >= 20) && (i < 23);
      vecs[i].run  = (i >= 22);
      vecs[i].en   = (i >= 26) && (((i - 26) % 4) == 0);
    end

    Clear_b    = 1'b0;
    bus.Rate   = 2'b01;
    bus.Toggle = 1'b0;
    bus.Step   = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_enable", bus.Enable, 1'b0);
    check("reset_running", bus.Running, 1'b0);
    Clear_b = 1'b1;

    for (int i = 0; i < NVEC; i++)
      cyc_chk("table", vecs[i].tog, vecs[i].stp, vecs[i].rate, vecs[i].en, vecs[i].run);

    // Rate changes while running: change cycles never pulse.
    cyc_chk("chg_to_2", 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc_chk("rate2_mid", 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    cyc_chk("chg_to_fast", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc_chk("fast_run", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cyc_chk("chg_to_3", 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) cyc_chk("rate3_first", 1'b0, 1'b0, 2'b11, i == 16, 1'b1);

    // Stop, then three single steps spaced 10 cycles apart.
    for (int i = 0; i < 6; i++) cyc_chk("stop", i == 0, 1'b0, 2'b11, 1'b0, i < 2);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 10; i++) cyc_chk("step", 1'b0, i == 0, 2'b11, i == 2, 1'b0);

    // Toggle and Step rise together: Toggle wins; later Step while running ignored.
    for (int i = 0; i < 3; i++) cyc_chk("pre_tog", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      cyc_chk("tog_step", i == 0, (i == 0) || (i == 7), 2'b01,
              (i == 6) || (i == 10) || (i == 14), i >= 2);

    // Enable is high now; asynchronous clear between edges drops it at once.
    #2;
    Clear_b = 1'b0;
    #1;
    check("async_clr_enable", bus.Enable, 1'b0);
    check("async_clr_running", bus.Running, 1'b0);
    repeat (2) @(posedge Clock);
    #1;
    Clear_b = 1'b1;
    for (int i = 0; i < 20; i++) cyc_chk("post_clr", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);

    // Randomized phase from a fresh reset.
    Clear_b = 1'b0;
    bus.Toggle = 1'b0;
    bus.Step   = 1'b0;
    bus.Rate   = 2'b01;
    repeat (2) @(posedge Clock);
    #1;
    Clear_b   = 1'b1;
    tog_l     = 1'b0;
    stp_l     = 1'b0;
    rate_l    = 2'b01;
    run_m     = 1'b0;
    next_due  = 0;
    prev_rate = 2'b00;
    for (int n = 0; n < NRND; n++) begin
      if ($urandom_range(0, 29) == 0) tog_l = ~tog_l;
      if ($urandom_range(0, 7) == 0) stp_l = ~stp_l;
      if ($urandom_range(0, 39) == 0) rate_l = 2'($urandom_range(0, 3));
      tog_a[n]  = tog_l;
      stp_a[n]  = stp_l;
      rate_a[n] = rate_l;
      cyc(tog_l, stp_l, rate_l);

      // An input rise seen before edge n-2 (low before n-3) acts at edge n.
      t_act = (n >= 2) && tog_a[n-2] && !((n >= 3) && tog_a[n-3]);
      s_act = (n >= 2) && stp_a[n-2] && !((n >= 3) && stp_a[n-3]);
      chg   = (rate_a[n] != prev_rate);
      prev_rate = rate_a[n];
      exp_en = 1'b0;
      if (t_act) begin
        run_m = !run_m;
        if (run_m) next_due = n + div_of(rate_a[n]);
      end else if (run_m) begin
        if (chg) next_due = n + div_of(rate_a[n]);
        else if (n == next_due) begin
          exp_en   = 1'b1;
          next_due = n + div_of(rate_a[n]);
        end
      end else begin
        exp_en = s_act;
      end
      check("rnd_enable", bus.Enable, exp_en);
      check("rnd_running", bus.Running, run_m);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
